// File: rtl/root_subinst_rr_arbiter.sv
// Round-robin arbiter granting one child instance at a time, with a bounded
// grant tenure (forced revocation plus error pulse) and a one-cycle recovery gap.
module root_subinst_rr_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         gnt_id,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [2:0]         gnt_id_q;
    logic [2:0]         last_q;
    logic               busy_q;
    logic               terr_q;
    logic [7:0]         hold_q;

    logic [2:0]         win_id_d;
    logic               win_vld_d;
    logic [3:0]         cand;

    // Search starts one past the last winner and wraps at NUM_REQ.
    always_comb begin
        win_id_d  = last_q;
        win_vld_d = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_q} + 4'(i);
            if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
            if (!win_vld_d && req[cand[2:0]]) begin
                win_vld_d = 1'b1;
                win_id_d  = cand[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            last_q   <= 3'(NUM_REQ - 1);
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            terr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        state_q  <= GRANT;
                        gnt_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id_d;
                        gnt_id_q <= win_id_d;
                        last_q   <= win_id_d;
                        busy_q   <= 1'b1;
                        hold_q   <= '0;
                    end
                end
                GRANT: begin
                    // A release wins over a simultaneous timeout.
                    if (rel[gnt_id_q]) begin
                        state_q <= RECOVER;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (hold_q == 8'(TIMEOUT - 1)) begin
                        state_q <= RECOVER;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        terr_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                RECOVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule
